// File: rtl/somatorio_pkg.sv
// rtl/somatorio_pkg.sv - shared state encoding and step constants for the summation unit
package somatorio_pkg;

  typedef enum logic [1:0] {
    OCIOSO        = 2'b00,
    CARREGA_TESTA = 2'b01,
    SOMA          = 2'b10,
    FIM           = 2'b11
  } estado_t;

  localparam logic [1:0] PASSO_UM   = 2'd1;
  localparam logic [1:0] PASSO_DOIS = 2'd2;

endpackage

// File: rtl/somatorio_dp.sv
// rtl/somatorio_dp.sv - down-counter, accumulator, carry adder and zero detect
module somatorio_dp
  import somatorio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 ck,
  input  logic                 reset,
  input  logic                 set,
  input  logic                 dec,
  input  logic                 cac,
  input  logic                 clr_ovf,
  input  logic [WIDTH-1:0]     n,
  input  logic                 passo_dois,
  output logic                 zero,
  output logic                 carry,
  output logic [ACC_WIDTH-1:0] resultado,
  output logic                 overflow
);

  logic [WIDTH-1:0] contador;
  logic [1:0]       passo;
  logic [WIDTH-1:0] passo_ext;
  logic [ACC_WIDTH:0] soma_ext;

  assign passo_ext = WIDTH'(passo);
  assign soma_ext  = {1'b0, resultado} + (ACC_WIDTH + 1)'(contador);
  assign carry     = soma_ext[ACC_WIDTH];
  assign zero      = (contador == '0);

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      contador  <= '0;
      passo     <= PASSO_UM;
      resultado <= '0;
      overflow  <= 1'b0;
    end else begin
      if (set) begin
        contador  <= n;
        passo     <= passo_dois ? PASSO_DOIS : PASSO_UM;
        resultado <= '0;
      end
      if (clr_ovf)
        overflow <= 1'b0;
      // on a carry the accumulator keeps the last sum that still fitted
      if (cac) begin
        if (carry)
          overflow <= 1'b1;
        else
          resultado <= soma_ext[ACC_WIDTH-1:0];
      end
      // saturate at zero so the counter never wraps
      if (dec)
        contador <= (contador < passo_ext) ? '0 : contador - passo_ext;
    end
  end

endmodule

// File: rtl/somatorio_param.sv
// rtl/somatorio_param.sv - iterative summation unit: control FSM plus datapath
module somatorio_param
  import somatorio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 ck,
  input  logic                 reset,
  input  logic                 inicio,
  input  logic [WIDTH-1:0]     n,
  input  logic                 passo_dois,
  output logic                 pronto,
  output logic                 ocupado,
  output logic                 overflow,
  output logic [ACC_WIDTH-1:0] resultado
);

  estado_t estado, proximo;
  logic set, dec, cac, clr_ovf;
  logic zero, carry;

  somatorio_dp #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_dp (
    .ck        (ck),
    .reset     (reset),
    .set       (set),
    .dec       (dec),
    .cac       (cac),
    .clr_ovf   (clr_ovf),
    .n         (n),
    .passo_dois(passo_dois),
    .zero      (zero),
    .carry     (carry),
    .resultado (resultado),
    .overflow  (overflow)
  );

  always_ff @(posedge ck or posedge reset) begin
    if (reset)
      estado <= OCIOSO;
    else
      estado <= proximo;
  end

  always_comb begin
    proximo = estado;
    set     = 1'b0;
    dec     = 1'b0;
    cac     = 1'b0;
    clr_ovf = 1'b0;
    case (estado)
      OCIOSO: begin
        if (inicio) begin
          set     = 1'b1;
          clr_ovf = 1'b1;
          proximo = CARREGA_TESTA;
        end
      end
      CARREGA_TESTA: proximo = zero ? FIM : SOMA;
      SOMA: begin
        cac     = 1'b1;
        dec     = ~carry;
        proximo = carry ? FIM : CARREGA_TESTA;
      end
      FIM:     proximo = OCIOSO;
      default: proximo = OCIOSO;
    endcase
  end

  assign pronto  = (estado == OCIOSO) || (estado == FIM);
  assign ocupado = ~pronto;

endmodule

// File: tb/tb_somatorio_param.sv
// tb/tb_somatorio_param.sv - self-checking bench for somatorio_param
module tb_somatorio_param;

  logic        ck = 1'b0;
  logic        reset = 1'b0;
  logic        inicio_a = 1'b0, inicio_b = 1'b0;
  logic [7:0]  n = '0;
  logic        passo_dois = 1'b0;
  logic        pronto_a, ocupado_a, overflow_a;
  logic [15:0] resultado_a;
  logic        pronto_b, ocupado_b, overflow_b;
  logic [7:0]  resultado_b;

  int tests = 0;
  int fails = 0;
  int sel   = 0;

  somatorio_param dut_a (
    .ck(ck), .reset(reset), .inicio(inicio_a), .n(n), .passo_dois(passo_dois),
    .pronto(pronto_a), .ocupado(ocupado_a), .overflow(overflow_a), .resultado(resultado_a)
  );

  somatorio_param #(.WIDTH(8), .ACC_WIDTH(8)) dut_b (
    .ck(ck), .reset(reset), .inicio(inicio_b), .n(n), .passo_dois(passo_dois),
    .pronto(pronto_b), .ocupado(ocupado_b), .overflow(overflow_b), .resultado(resultado_b)
  );

  always #5 ck = ~ck;

  logic        pr, oc, ov;
  logic [15:0] res;
  always_comb begin
    pr  = (sel == 1) ? pronto_b   : pronto_a;
    oc  = (sel == 1) ? ocupado_b  : ocupado_a;
    ov  = (sel == 1) ? overflow_b : overflow_a;
    res = (sel == 1) ? {8'h00, resultado_b} : resultado_a;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: walk the terms n, n-P, ... and stop on the first one that no longer fits.
  task automatic modelo(input int nv, input bit p, input int accw,
                        output int r, output bit o, output int lat);
    int termo, k;
    longint limite;
    limite = longint'(1) << accw;
    r = 0; o = 1'b0; k = 0;
    termo = nv;
    while (termo > 0) begin
      if (longint'(r) + termo >= limite) begin
        o = 1'b1;
        break;
      end
      r += termo;
      k++;
      termo -= p ? 2 : 1;
    end
    lat = 2 * k + 2 + (o ? 1 : 0);
  endtask

  task automatic start(input int s, input int nv, input bit p);
    @(negedge ck);
    sel = s;
    n = 8'(nv);
    passo_dois = p;
    if (s == 1) inicio_b = 1'b1; else inicio_a = 1'b1;
    @(posedge ck);
    #1;
    inicio_a = 1'b0;
    inicio_b = 1'b0;
  endtask

  // disturb: corrupt n/passo_dois and pulse inicio while the run is in progress
  task automatic run(input string tag, input int s, input int nv, input bit p, input bit disturb);
    int r, lat, edges;
    bit o;
    modelo(nv, p, (s == 1) ? 8 : 16, r, o, lat);
    start(s, nv, p);
    chk({tag, ".busy"}, {31'd0, oc}, 32'd1);
    edges = 1;
    while (!pr && edges < 1000) begin
      if (disturb && edges == 4) begin
        n = 8'd200;
        passo_dois = ~p;
        if (s == 1) inicio_b = 1'b1; else inicio_a = 1'b1;
      end else begin
        inicio_a = 1'b0;
        inicio_b = 1'b0;
      end
      @(posedge ck);
      #1;
      edges++;
    end
    inicio_a = 1'b0;
    inicio_b = 1'b0;
    chk({tag, ".lat"}, edges, lat);
    chk({tag, ".res"}, {16'd0, res}, r);
    chk({tag, ".ovf"}, {31'd0, ov}, {31'd0, o});
    chk({tag, ".ocupado"}, {31'd0, oc}, 32'd0);
    @(posedge ck);
    #1;
    chk({tag, ".hold"}, {16'd0, res}, r);
  endtask

  initial begin
    reset = 1'b1;
    inicio_a = 1'b1;
    inicio_b = 1'b1;
    n = 8'd9;
    #2;
    chk("rst.res", {16'd0, resultado_a}, 0);
    chk("rst.ovf", {31'd0, overflow_a}, 0);
    chk("rst.pronto", {31'd0, pronto_a}, 1);
    chk("rst.ocupado", {31'd0, ocupado_a}, 0);
    repeat (2) @(posedge ck);
    #1;
    chk("rst.held_pronto", {31'd0, pronto_a}, 1);
    @(negedge ck);
    inicio_a = 1'b0;
    inicio_b = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge ck);
    #1;
    chk("rst.nostart", {31'd0, pronto_a}, 1);
    chk("rst.nostart_res", {16'd0, resultado_a}, 0);

    run("n10s1", 0, 10, 1'b0, 1'b0);
    run("n4s2", 0, 4, 1'b1, 1'b0);
    run("n5s2", 0, 5, 1'b1, 1'b0);
    run("n0", 0, 0, 1'b0, 1'b0);
    run("n1s2", 0, 1, 1'b1, 1'b0);
    run("n255", 0, 255, 1'b0, 1'b0);
    run("ovf23", 1, 23, 1'b0, 1'b0);
    chk("ovf23.abs", {24'd0, resultado_b}, 255);
    run("after_ovf", 1, 3, 1'b0, 1'b0);
    run("disturb", 0, 10, 1'b0, 1'b1);

    for (int i = 0; i < 12; i++) begin
      run("rnd16", 0, int'($urandom_range(0, 255)), 1'($urandom), 1'b0);
      run("rnd8", 1, int'($urandom_range(0, 40)), 1'($urandom), 1'b0);
    end

    start(0, 50, 1'b0);
    repeat (7) @(posedge ck);
    #3;
    reset = 1'b1;
    #1;
    chk("abort.res", {16'd0, resultado_a}, 0);
    chk("abort.ovf", {31'd0, overflow_a}, 0);
    chk("abort.pronto", {31'd0, pronto_a}, 1);
    chk("abort.ocupado", {31'd0, ocupado_a}, 0);
    @(negedge ck);
    reset = 1'b0;
    repeat (2) @(posedge ck);
    #1;
    chk("abort.idle", {31'd0, pronto_a}, 1);
    run("post_abort", 0, 6, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/somatorio_param.md
Name: somatorio_param

Overview:
- Self-contained iterative summation unit with control FSM and datapath in one block.
- On `inicio`, computes S = n + (n-P) + (n-2P) + … over all positive terms, where P = 1 or 2 as selected by `passo_dois`.
- Reports `pronto`, `ocupado` and `overflow`.
- Successor to the fixed-width summation FSM. Adds: parametrised widths, a selectable step mode, an integrated counter/accumulator, carry-based overflow with early termination, and a busy handshake.

Parameters:
- WIDTH, 8, width of operand `n` and of the down-counter.
- ACC_WIDTH, 16, width of the accumulator and of `resultado`; must be ≥ WIDTH.

Ports:
- ck  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- inicio  input  1  start request; sampled only in OCIOSO.
- n  input  WIDTH  starting term; sampled with `inicio`.
- passo_dois  input  1  0: step 1 (n+…+1); 1: step 2 (n+(n-2)+…); sampled with `inicio`.
- pronto  output  1  high in OCIOSO and FIM; `resultado`/`overflow` valid while high.
- ocupado  output  1  high in CARREGA_TESTA and SOMA.
- overflow  output  1  set when an addition carries out of ACC_WIDTH bits; cleared on the next start.
- resultado  output  ACC_WIDTH  accumulator value.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state = OCIOSO, counter = 0
  - resultado = 0, overflow = 0
  - pronto = 1, ocupado = 0
- Reset mid-computation aborts immediately; no partial result is retained.
- States: OCIOSO, CARREGA_TESTA (written "TESTA" below), SOMA, FIM; binary encoding.
- OCIOSO:
  - If `inicio`=1: counter ← n; step ← passo_dois ? 2 : 1; resultado ← 0; overflow ← 0; go to TESTA.
  - Otherwise hold all registers.
- TESTA:
  - If counter == 0, go to FIM.
  - Else go to SOMA.
- SOMA:
  - Compute {carry, sum} = resultado + zero-extended counter, at ACC_WIDTH+1 bits.
  - If carry=1: overflow ← 1; resultado is NOT updated (keeps the last non-overflowing sum); go to FIM.
  - Else: resultado ← sum; counter ← (counter < step) ? 0 : counter − step; go to TESTA.
  - The counter never wraps below 0.
- FIM: one cycle; go to OCIOSO unconditionally.
- `pronto` and `ocupado` are Moore outputs decoded from state; exactly one of them is high at any time.
- `inicio` in any state other than OCIOSO is ignored; it is not queued.
- `inicio` held high continuously restarts one cycle after FIM, with a new sample of `n`.
- Changes to `n` or `passo_dois` after the start edge have no effect on the running computation.
- Latency, with the start edge counted as edge 1 and k = number of terms added:
  - `pronto` is low from edge 1 and rises at edge 2k+2.
  - n=0 gives k=0: `pronto` is low for exactly one cycle (TESTA); resultado = 0.
- `resultado` is stable while `pronto`=1 and is changed only by a start or a reset.

Decomposition:
- Shared package `somatorio_pkg`:
  - state encoding constants OCIOSO=2'b00, CARREGA_TESTA=2'b01, SOMA=2'b10, FIM=2'b11
  - step constants PASSO_UM=1, PASSO_DOIS=2
- One natural sub-module, `somatorio_dp`: counter, accumulator, adder with carry, and the zero comparator.
  - Driven by the FSM strobes `set`, `dec`, `cac`, `clr_ovf`.
  - Returns `zero` and `carry`.
- The top level holds the FSM and output decode.

Test Plan:
- Reset while `inicio`=1 → resultado=0, overflow=0, pronto=1, ocupado=0; after release, no start occurs until `inicio` is sampled in OCIOSO.
- Defaults, n=10, passo_dois=0 → resultado=55, overflow=0, `pronto` rises at edge 22.
- n=4, passo_dois=1 → resultado=6 (4+2), latency 6 edges; n=5, passo_dois=1 → resultado=9 (5+3+1).
- n=0 → `pronto` low for one cycle, resultado=0; n=1, passo_dois=1 → resultado=1.
- ACC_WIDTH=8, n=23, passo_dois=0 → overflow=1, resultado=255 (the addition of term 6 carries out), FIM reached early; the next start with n=3 → overflow=0, resultado=6.
- `inicio` pulsed during SOMA, and `n` changed mid-run → both ignored, result unchanged; reset asserted mid-run → outputs return to reset values asynchronously.
